generic_bus_arbiter_n: RTL and testbench

- N-requester, single-manager arbiter on the generic bus request/busy protocol.
- Generalises the fixed two-port icache/dcache memory controller to N_PORTS requesters. Adds selectable fixed-priority or round-robin arbitration, plus a starvation limit in fixed mode.
- Sits between the cache/uncached requesters and the bus-translation block (generic_nonpipeline or ahb).
- Grants one complete transaction at a time and holds the grant until the downstream side completes it.

---
 rtl/generic_bus_arbiter_n.sv | 169 ++++++++++++++++
 tb/tb_generic_bus_arbiter_n.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_bus_arbiter_n.sv
// N-requester, single-manager arbiter for the generic request/busy bus.
// One whole transaction is granted at a time. The grant is held until the
// downstream side completes it. Arbitration is round-robin or fixed priority,
// and fixed priority includes a starvation override.
module generic_bus_arbiter_n #(
  parameter int unsigned N_PORTS      = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RR_MODE      = 1,
  parameter int unsigned STARVE_LIMIT = 16,
  localparam int unsigned GW          = $clog2(N_PORTS),
  localparam int unsigned BE_W        = DATA_W / 8
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [N_PORTS-1:0]        in_ren,
  input  logic [N_PORTS-1:0]        in_wen,
  input  logic [N_PORTS*ADDR_W-1:0] in_addr,
  input  logic [N_PORTS*DATA_W-1:0] in_wdata,
  input  logic [N_PORTS*BE_W-1:0]   in_byte_en,
  output logic [DATA_W-1:0]         in_rdata,
  output logic [N_PORTS-1:0]        in_busy,
  output logic                      out_ren,
  output logic                      out_wen,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_wdata,
  output logic [BE_W-1:0]           out_byte_en,
  input  logic [DATA_W-1:0]         out_rdata,
  input  logic                      out_busy,
  output logic [GW-1:0]             grant_idx,
  output logic                      grant_valid
);

  // Starvation counters only need to reach the limit; they saturate there.
  localparam int unsigned CW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   starve_q [N_PORTS];
  logic [CW-1:0]   starve_d [N_PORTS];
  logic [GW-1:0]   win_c;
  logic [N_PORTS-1:0] req_c;

  logic [ADDR_W-1:0] addr_a  [N_PORTS];
  logic [DATA_W-1:0] wdata_a [N_PORTS];
  logic [BE_W-1:0]   be_a    [N_PORTS];

  assign req_c = in_ren | in_wen;

  // Split the flat per-port buses into indexable arrays.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign addr_a[i]  = in_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = in_wdata[i*DATA_W +: DATA_W];
    assign be_a[i]    = in_byte_en[i*BE_W +: BE_W];
  end

  // Pick the winner among the current requesters.
  always_comb begin
    logic        found;
    int unsigned idx;
    found = 1'b0;
    idx   = 0;
    win_c = '0;
    if (RR_MODE != 0) begin
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= N_PORTS) idx = idx - N_PORTS;
        if (!found && req_c[GW'(idx)]) begin
          found = 1'b1;
          win_c = GW'(idx);
        end
      end
    end else begin
      if (STARVE_LIMIT != 0) begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
          if (!found && req_c[GW'(p)] && (starve_q[GW'(p)] >= CW'(STARVE_LIMIT))) begin
            found = 1'b1;
            win_c = GW'(p);
          end
        end
      end
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (!found && req_c[GW'(p)]) begin
          found = 1'b1;
          win_c = GW'(p);
        end
      end
    end
  end

  // Next state: grant from IDLE, release on downstream completion.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (|req_c) begin
          state_d = ACTIVE;
          grant_d = win_c;
          if (RR_MODE == 0) begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
              if (GW'(p) == win_c) begin
                starve_d[GW'(p)] = '0;
              end else if (req_c[GW'(p)] && (starve_q[GW'(p)] < CW'(STARVE_LIMIT))) begin
                starve_d[GW'(p)] = starve_q[GW'(p)] + CW'(1);
              end
            end
          end
        end
      end
      ACTIVE: begin
        if (!out_busy) begin
          state_d = IDLE;
          ptr_d   = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      starve_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
    end
  end

  // Steer the granted port to the downstream side and return completion.
  always_comb begin
    out_ren     = 1'b0;
    out_wen     = 1'b0;
    out_addr    = '0;
    out_wdata   = '0;
    out_byte_en = '0;
    in_rdata    = '0;
    in_busy     = '1;
    if (state_q == ACTIVE) begin
      out_wen     = in_wen[grant_q];
      out_ren     = in_ren[grant_q] & ~in_wen[grant_q];
      out_addr    = addr_a[grant_q];
      out_wdata   = wdata_a[grant_q];
      out_byte_en = be_a[grant_q];
      if (!out_busy) begin
        in_busy[grant_q] = 1'b0;
        in_rdata         = out_rdata;
      end
    end
  end

  assign grant_idx   = grant_q;
  assign grant_valid = (state_q == ACTIVE);

endmodule

// File: tb/tb_generic_bus_arbiter_n.sv
// Bench for generic_bus_arbiter_n: a round-robin instance (4 ports) and a
// fixed-priority instance (3 ports, starvation limit 2) share clock and reset.
module tb_generic_bus_arbiter_n;

  localparam int RN = 4;
  localparam int FN = 3;

  logic CLK;
  logic nrst;
  int   checks   = 0;
  int   failures = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Round-robin instance signals
  logic [RN-1:0]    r_ren, r_wen, r_busy;
  logic [RN*32-1:0] r_addr, r_wdata;
  logic [RN*4-1:0]  r_be;
  logic [31:0]      r_ordata, r_rdata, r_oaddr, r_owdata;
  logic             r_obusy, r_oren, r_owen, r_gvalid;
  logic [3:0]       r_obe;
  logic [1:0]       r_gidx;

  // Fixed-priority instance signals
  logic [FN-1:0]    f_ren, f_wen, f_busy;
  logic [FN*32-1:0] f_addr, f_wdata;
  logic [FN*4-1:0]  f_be;
  logic [31:0]      f_ordata, f_rdata, f_oaddr, f_owdata;
  logic             f_obusy, f_oren, f_owen, f_gvalid;
  logic [3:0]       f_obe;
  logic [1:0]       f_gidx;

  generic_bus_arbiter_n #(.N_PORTS(RN), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .STARVE_LIMIT(16)) dut_rr (
    .CLK(CLK), .nRST(nrst), .in_ren(r_ren), .in_wen(r_wen), .in_addr(r_addr),
    .in_wdata(r_wdata), .in_byte_en(r_be), .in_rdata(r_rdata), .in_busy(r_busy),
    .out_ren(r_oren), .out_wen(r_owen), .out_addr(r_oaddr), .out_wdata(r_owdata),
    .out_byte_en(r_obe), .out_rdata(r_ordata), .out_busy(r_obusy),
    .grant_idx(r_gidx), .grant_valid(r_gvalid));

  generic_bus_arbiter_n #(.N_PORTS(FN), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .STARVE_LIMIT(2)) dut_fx (
    .CLK(CLK), .nRST(nrst), .in_ren(f_ren), .in_wen(f_wen), .in_addr(f_addr),
    .in_wdata(f_wdata), .in_byte_en(f_be), .in_rdata(f_rdata), .in_busy(f_busy),
    .out_ren(f_oren), .out_wen(f_owen), .out_addr(f_oaddr), .out_wdata(f_owdata),
    .out_byte_en(f_obe), .out_rdata(f_ordata), .out_busy(f_obusy),
    .grant_idx(f_gidx), .grant_valid(f_gvalid));

  task automatic drive_idle();
    r_ren = '0; r_wen = '0; r_addr = '0; r_wdata = '0; r_be = '0; r_ordata = '0; r_obusy = 1'b0;
    f_ren = '0; f_wen = '0; f_addr = '0; f_wdata = '0; f_be = '0; f_ordata = '0; f_obusy = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive_idle();
    @(negedge CLK);
    nrst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    r_ren = 4'($urandom); r_wen = 4'($urandom); r_addr = {$urandom, $urandom, $urandom, $urandom};
    r_obusy = 1'($urandom); r_ordata = $urandom;
    f_ren = 3'($urandom); f_wen = 3'($urandom); f_addr = {$urandom, $urandom, $urandom};
    f_obusy = 1'($urandom); f_ordata = $urandom;
    @(negedge CLK);
    checks++;
    if (r_busy !== 4'hF || r_gvalid !== 1'b0 || r_oren !== 1'b0 || r_owen !== 1'b0) begin
      failures++;
      $display("FAIL reset_rr busy=%b gv=%b ren=%b wen=%b required busy=1111 gv=0 ren=0 wen=0", r_busy, r_gvalid, r_oren, r_owen);
    end
    checks++;
    if (r_oaddr !== 32'h0 || r_owdata !== 32'h0 || r_obe !== 4'h0 || r_rdata !== 32'h0 || r_gidx !== 2'd0) begin
      failures++;
      $display("FAIL reset_rr_data addr=%h wdata=%h be=%h rdata=%h gidx=%0d required all zero", r_oaddr, r_owdata, r_obe, r_rdata, r_gidx);
    end
    checks++;
    if (f_busy !== 3'h7 || f_gvalid !== 1'b0 || f_oren !== 1'b0 || f_owen !== 1'b0) begin
      failures++;
      $display("FAIL reset_fx busy=%b gv=%b ren=%b wen=%b required busy=111 gv=0 ren=0 wen=0", f_busy, f_gvalid, f_oren, f_owen);
    end
    step();
    checks++;
    if (r_gvalid !== 1'b0 || f_gvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_held gv_rr=%b gv_fx=%b required 0 0", r_gvalid, f_gvalid);
    end
    drive_idle();
    @(negedge CLK);
    nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge CLK);
      checks++;
      if (r_gvalid !== 1'b0 || r_busy !== 4'hF || f_gvalid !== 1'b0 || f_busy !== 3'h7) begin
        failures++;
        $display("FAIL idle_no_req cyc=%0d gv_rr=%b busy_rr=%b gv_fx=%b busy_fx=%b required 0 1111 0 111", c, r_gvalid, r_busy, f_gvalid, f_busy);
      end
    end
    step();
  endtask

  task automatic test_single_read();
    do_reset();
    r_ren[2] = 1'b1;
    r_addr[2*32 +: 32] = 32'h8000_0010;
    r_obusy = 1'b1;
    @(negedge CLK);
    checks++;
    if (r_gvalid !== 1'b0 || r_busy !== 4'hF || r_oren !== 1'b0) begin
      failures++;
      $display("FAIL single_arb_cycle gv=%b busy=%b ren=%b required 0 1111 0", r_gvalid, r_busy, r_oren);
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) begin
        r_obusy  = 1'b0;
        r_ordata = 32'hDEAD_BEEF;
      end
      @(negedge CLK);
      checks++;
      if (r_gvalid !== 1'b1 || r_gidx !== 2'd2 || r_oaddr !== 32'h8000_0010 || r_oren !== 1'b1 || r_owen !== 1'b0) begin
        failures++;
        $display("FAIL single_active cyc=%0d gv=%b gidx=%0d addr=%h ren=%b wen=%b required 1 2 80000010 1 0", c, r_gvalid, r_gidx, r_oaddr, r_oren, r_owen);
      end
      checks++;
      if (r_busy !== ((c == 4) ? 4'b1011 : 4'b1111)) begin
        failures++;
        $display("FAIL single_busy cyc=%0d busy=%b required %b", c, r_busy, (c == 4) ? 4'b1011 : 4'b1111);
      end
      if (c == 4) begin
        checks++;
        if (r_rdata !== 32'hDEAD_BEEF) begin
          failures++;
          $display("FAIL single_rdata rdata=%h required deadbeef", r_rdata);
        end
      end
    end
    step();
    r_ren   = '0;
    r_obusy = 1'b1;
    @(negedge CLK);
    checks++;
    if (r_gvalid !== 1'b0 || r_busy !== 4'hF) begin
      failures++;
      $display("FAIL single_after gv=%b busy=%b required 0 1111", r_gvalid, r_busy);
    end
    step();
    r_obusy = 1'b0;
  endtask

  task automatic test_rr_fairness();
    int ord [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0] eb;
    do_reset();
    for (int p = 0; p < RN; p++) r_addr[p*32 +: 32] = 32'h1000 + 32'(p * 16);
    r_ren   = 4'b1011;
    r_obusy = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      checks++;
      if ((c % 2) == 0) begin
        if (r_gvalid !== 1'b0 || r_busy !== 4'hF) begin
          failures++;
          $display("FAIL rr_gap cyc=%0d gv=%b busy=%b required 0 1111", c, r_gvalid, r_busy);
        end
      end else begin
        eb = 4'hF;
        eb[ord[c/2]] = 1'b0;
        if (r_gvalid !== 1'b1 || r_gidx !== 2'(ord[c/2]) || r_busy !== eb || r_oaddr !== 32'h1000 + 32'(ord[c/2] * 16)) begin
          failures++;
          $display("FAIL rr_order cyc=%0d gv=%b gidx=%0d busy=%b addr=%h required 1 %0d %b %h", c, r_gvalid, r_gidx, r_busy, r_oaddr, ord[c/2], eb, 32'h1000 + 32'(ord[c/2] * 16));
        end
      end
      step();
    end
    r_ren = '0;
  endtask

  task automatic test_fixed_starve();
    int ord [6] = '{0, 0, 1, 0, 0, 1};
    do_reset();
    f_ren   = 3'b011;
    f_obusy = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      checks++;
      if ((c % 2) == 0) begin
        if (f_gvalid !== 1'b0) begin
          failures++;
          $display("FAIL fx_gap cyc=%0d gv=%b required 0", c, f_gvalid);
        end
      end else if (f_gvalid !== 1'b1 || f_gidx !== 2'(ord[c/2])) begin
        failures++;
        $display("FAIL fx_order cyc=%0d gv=%b gidx=%0d required 1 %0d", c, f_gvalid, f_gidx, ord[c/2]);
      end
      step();
    end
    f_ren = '0;
  endtask

  task automatic test_write_priority();
    r_ren[1] = 1'b1;
    r_wen[1] = 1'b1;
    r_be[4 +: 4] = 4'b0011;
    r_wdata[32 +: 32] = 32'h1234_5678;
    r_addr[32 +: 32]  = 32'h0000_00A0;
    r_obusy = 1'b1;
    step();
    @(negedge CLK);
    checks++;
    if (r_owen !== 1'b1 || r_oren !== 1'b0 || r_obe !== 4'b0011 || r_owdata !== 32'h1234_5678 || r_gidx !== 2'd1) begin
      failures++;
      $display("FAIL write_prio wen=%b ren=%b be=%b wdata=%h gidx=%0d required 1 0 0011 12345678 1", r_owen, r_oren, r_obe, r_owdata, r_gidx);
    end
    step();
    r_obusy = 1'b0;
    @(negedge CLK);
    checks++;
    if (r_busy !== 4'b1101 || r_owen !== 1'b1) begin
      failures++;
      $display("FAIL write_done busy=%b wen=%b required 1101 1", r_busy, r_owen);
    end
    step();
    r_ren = '0; r_wen = '0;
    step();
  endtask

  task automatic test_reset_mid_active();
    r_ren[0] = 1'b1;
    r_addr[0 +: 32] = 32'h0000_0055;
    r_obusy = 1'b1;
    step();
    @(negedge CLK);
    checks++;
    if (r_gvalid !== 1'b1 || r_oren !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre gv=%b ren=%b required 1 1", r_gvalid, r_oren);
    end
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (r_gvalid !== 1'b0 || r_oren !== 1'b0 || r_busy !== 4'hF || r_oaddr !== 32'h0 || r_gidx !== 2'd0) begin
      failures++;
      $display("FAIL midrst_now gv=%b ren=%b busy=%b addr=%h gidx=%0d required 0 0 1111 0 0", r_gvalid, r_oren, r_busy, r_oaddr, r_gidx);
    end
    @(negedge CLK);
    nrst = 1'b1;
    #1;
    checks++;
    if (r_gvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_release gv=%b required 0", r_gvalid);
    end
    step();
    r_obusy = 1'b0;
    @(negedge CLK);
    checks++;
    if (r_gvalid !== 1'b1 || r_gidx !== 2'd0 || r_oaddr !== 32'h55 || r_busy !== 4'b1110) begin
      failures++;
      $display("FAIL midrst_regrant gv=%b gidx=%0d addr=%h busy=%b required 1 0 00000055 1110", r_gvalid, r_gidx, r_oaddr, r_busy);
    end
    step();
    r_ren = '0;
    step();
  endtask

  // Random traffic against a transaction-level model of the arbiter.
  task automatic test_random(input bit fx);
    int          n;
    bit          pend [4];
    bit          rd_a [4];
    bit          wr_a [4];
    logic [31:0] ad [4];
    logic [31:0] wd [4];
    logic [3:0]  be [4];
    int          st [4];
    int          gnt, ptr, w, k;
    logic        obusy;
    logic [31:0] ordata;
    logic        gv, oren, owen;
    logic [1:0]  gi;
    logic [3:0]  bz, eb, obe;
    logic [31:0] oaddr, owdata, rdata;
    n = fx ? FN : RN;
    gnt = -1;
    ptr = 0;
    for (int p = 0; p < 4; p++) begin
      pend[p] = 1'b0; rd_a[p] = 1'b0; wr_a[p] = 1'b0; ad[p] = '0; wd[p] = '0; be[p] = '0; st[p] = 0;
    end
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < n; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          k = $urandom_range(0, 2);
          rd_a[p] = (k != 1);
          wr_a[p] = (k != 0);
          ad[p] = $urandom;
          wd[p] = $urandom;
          be[p] = 4'($urandom_range(1, 15));
        end
      end
      obusy  = 1'($urandom_range(0, 1));
      ordata = $urandom;
      for (int p = 0; p < n; p++) begin
        if (fx) begin
          f_ren[p] = pend[p] & rd_a[p]; f_wen[p] = pend[p] & wr_a[p];
          f_addr[p*32 +: 32] = ad[p]; f_wdata[p*32 +: 32] = wd[p]; f_be[p*4 +: 4] = be[p];
        end else begin
          r_ren[p] = pend[p] & rd_a[p]; r_wen[p] = pend[p] & wr_a[p];
          r_addr[p*32 +: 32] = ad[p]; r_wdata[p*32 +: 32] = wd[p]; r_be[p*4 +: 4] = be[p];
        end
      end
      if (fx) begin f_obusy = obusy; f_ordata = ordata; end
      else    begin r_obusy = obusy; r_ordata = ordata; end
      @(negedge CLK);
      if (fx) begin
        gv = f_gvalid; gi = f_gidx; bz = {1'b1, f_busy}; oren = f_oren; owen = f_owen;
        oaddr = f_oaddr; owdata = f_owdata; obe = f_obe; rdata = f_rdata;
      end else begin
        gv = r_gvalid; gi = r_gidx; bz = r_busy; oren = r_oren; owen = r_owen;
        oaddr = r_oaddr; owdata = r_owdata; obe = r_obe; rdata = r_rdata;
      end
      eb = 4'hF;
      if (gnt < 0) begin
        checks++;
        if (gv !== 1'b0 || bz !== eb || {oren, owen, oaddr, owdata, obe} !== 70'h0) begin
          failures++;
          $display("FAIL rand_idle fx=%0d cyc=%0d gv=%b busy=%b ren=%b wen=%b addr=%h required 0 %b 0 0 0", fx, cyc, gv, bz, oren, owen, oaddr, eb);
        end
        w = -1;
        if (!fx) begin
          for (int j = 0; j < n; j++) if (w < 0 && pend[(ptr + j) % n]) w = (ptr + j) % n;
        end else begin
          for (int p = 0; p < n; p++) if (w < 0 && pend[p] && st[p] >= 2) w = p;
          for (int p = 0; p < n; p++) if (w < 0 && pend[p]) w = p;
          if (w >= 0) for (int p = 0; p < n; p++) begin
            if (p == w) st[p] = 0;
            else if (pend[p]) st[p] = st[p] + 1;
          end
        end
        gnt = w;
      end else begin
        if (!obusy) eb[gnt] = 1'b0;
        checks++;
        if (gv !== 1'b1 || gi !== 2'(gnt)) begin
          failures++;
          $display("FAIL rand_grant fx=%0d cyc=%0d gv=%b gidx=%0d required 1 %0d", fx, cyc, gv, gi, gnt);
        end
        checks++;
        if ({oren, owen, oaddr, owdata, obe} !== {rd_a[gnt] & ~wr_a[gnt], wr_a[gnt], ad[gnt], wd[gnt], be[gnt]}) begin
          failures++;
          $display("FAIL rand_mux fx=%0d cyc=%0d ren=%b wen=%b addr=%h wdata=%h be=%b required %b %b %h %h %b", fx, cyc,
                   oren, owen, oaddr, owdata, obe, rd_a[gnt] & ~wr_a[gnt], wr_a[gnt], ad[gnt], wd[gnt], be[gnt]);
        end
        checks++;
        if (bz !== eb) begin
          failures++;
          $display("FAIL rand_busy fx=%0d cyc=%0d busy=%b required %b", fx, cyc, bz, eb);
        end
        if (!obusy) begin
          checks++;
          if (rdata !== ordata) begin
            failures++;
            $display("FAIL rand_rdata fx=%0d cyc=%0d rdata=%h required %h", fx, cyc, rdata, ordata);
          end
          ptr = (gnt + 1) % n;
          pend[gnt] = 1'b0;
          gnt = -1;
        end
      end
      step();
    end
    drive_idle();
    step();
  endtask

  initial begin
    nrst = 1'b0;
    drive_idle();
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_fixed_starve();
    test_write_priority();
    test_reset_mid_active();
    test_random(1'b0);
    test_random(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
